// File: rtl/mmul_parallel_tile_sched_pkg.sv
// rtl/mmul_parallel_tile_sched_pkg.sv - shared types for the MMUL_PARALLEL tile-loop scheduler
package mmul_parallel_tile_sched_pkg;

   localparam int TS_OFFS_W = 32;
   localparam int TS_CNT_W  = 16;

   typedef logic [TS_OFFS_W-1:0] offs_t;
   typedef logic [TS_CNT_W-1:0]  cnt_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DONE  = 2'd2
   } state_tile_sched_t;

   typedef struct packed {
      cnt_t  n_m;
      cnt_t  n_n;
      cnt_t  n_k;
      offs_t str_a_m;
      offs_t str_a_k;
      offs_t str_b_k;
      offs_t str_b_n;
      offs_t str_c_m;
      offs_t str_c_n;
   } tile_cfg_t;

   typedef struct packed {
      offs_t a_offs;
      offs_t b_offs;
      offs_t c_offs;
      logic  acc_first;
      logic  acc_last;
   } tile_desc_t;

   // An empty loop level means the tile space is empty
   function automatic logic cfg_has_zero(input tile_cfg_t cfg);
      return (cfg.n_m == '0) || (cfg.n_n == '0) || (cfg.n_k == '0);
   endfunction

endpackage

// File: rtl/mmul_parallel_tile_sched_if.sv
// rtl/mmul_parallel_tile_sched_if.sv - tile descriptor handshake between scheduler and engine FSM
interface mmul_parallel_tile_sched_if
   import mmul_parallel_tile_sched_pkg::*;
#(
   parameter int OFFS_W = TS_OFFS_W
) ();

   logic              tile_valid;
   logic              tile_ready;
   logic [OFFS_W-1:0] a_offs;
   logic [OFFS_W-1:0] b_offs;
   logic [OFFS_W-1:0] c_offs;
   logic              acc_first;
   logic              acc_last;

   modport master (
      output tile_valid, a_offs, b_offs, c_offs, acc_first, acc_last,
      input  tile_ready
   );

   modport slave (
      input  tile_valid, a_offs, b_offs, c_offs, acc_first, acc_last,
      output tile_ready
   );

endinterface

// File: rtl/mmul_parallel_loop_cnt.sv
// rtl/mmul_parallel_loop_cnt.sv - one loop level of the tile walk: index, wrap and last detect
module mmul_parallel_loop_cnt
   import mmul_parallel_tile_sched_pkg::*;
#(
   parameter int CNT_W = TS_CNT_W
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             incr_i,
   input  logic [CNT_W-1:0] cnt_i,
   output logic             last_o,
   output logic             pre_last_o,
   output logic             wrap_o
);

   logic [CNT_W-1:0] idx_q;

   // pre_last flags the index just before the last one, so the caller can
   // register "next tile is last" without an extra adder on the index
   assign last_o     = (idx_q == cnt_i - CNT_W'(1));
   assign pre_last_o = (idx_q == cnt_i - CNT_W'(2));
   assign wrap_o     = incr_i & last_o;

   // Index register: clear wins, otherwise step and wrap back to zero after the last value
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         idx_q <= '0;
      end else if (clear_i) begin
         idx_q <= '0;
      end else if (incr_i) begin
         idx_q <= last_o ? '0 : idx_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/mmul_parallel_tile_sched.sv
// rtl/mmul_parallel_tile_sched.sv - M x N x K tile-loop scheduler (optional MMUL_PARALLEL_TILE_SCHED_PERF_EN stall counter)
module mmul_parallel_tile_sched
   import mmul_parallel_tile_sched_pkg::*;
#(
   parameter int OFFS_W = TS_OFFS_W,
   parameter int CNT_W  = TS_CNT_W
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              clear_i,
   input  logic              start_i,
   input  logic [CNT_W-1:0]  n_m_i,
   input  logic [CNT_W-1:0]  n_n_i,
   input  logic [CNT_W-1:0]  n_k_i,
   input  logic [OFFS_W-1:0] str_a_m_i,
   input  logic [OFFS_W-1:0] str_a_k_i,
   input  logic [OFFS_W-1:0] str_b_k_i,
   input  logic [OFFS_W-1:0] str_b_n_i,
   input  logic [OFFS_W-1:0] str_c_m_i,
   input  logic [OFFS_W-1:0] str_c_n_i,
`ifdef MMUL_PARALLEL_TILE_SCHED_PERF_EN
   output logic [31:0]       perf_stall_o,
`endif
   output logic              busy_o,
   output logic              done_o,
   mmul_parallel_tile_sched_if.master tile_if
);

   state_tile_sched_t state_q;
   tile_cfg_t         cfg_in;
   tile_cfg_t         cfg_q;
   tile_desc_t        desc_q;
   offs_t             a_row_q;   // m * str_a_m
   offs_t             b_col_q;   // n * str_b_n
   offs_t             c_row_q;   // m * str_c_m
   logic              valid_q;
   logic              busy_q;
   logic              done_q;

   logic hs;
   logic start_ok;
   logic idx_clr;
   logic k_last, k_pre, k_wrap;
   logic n_last, n_pre, n_wrap;
   logic m_last, m_pre, m_wrap;
   logic tile_last;
   logic unused_cnt;

   // Config as presented on the ports, in the latched layout
   always_comb begin
      cfg_in         = '0;
      cfg_in.n_m     = TS_CNT_W'(n_m_i);
      cfg_in.n_n     = TS_CNT_W'(n_n_i);
      cfg_in.n_k     = TS_CNT_W'(n_k_i);
      cfg_in.str_a_m = TS_OFFS_W'(str_a_m_i);
      cfg_in.str_a_k = TS_OFFS_W'(str_a_k_i);
      cfg_in.str_b_k = TS_OFFS_W'(str_b_k_i);
      cfg_in.str_b_n = TS_OFFS_W'(str_b_n_i);
      cfg_in.str_c_m = TS_OFFS_W'(str_c_m_i);
      cfg_in.str_c_n = TS_OFFS_W'(str_c_n_i);
   end

   assign hs        = valid_q & tile_if.tile_ready;
   assign start_ok  = (state_q == IDLE) & start_i;
   assign idx_clr   = clear_i | start_ok;
   assign tile_last = k_last & n_last & m_last;

   // k innermost, n middle, m outermost; each level steps when the one inside wraps
   mmul_parallel_loop_cnt #(.CNT_W(TS_CNT_W)) u_cnt_k (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .clear_i    (idx_clr),
      .incr_i     (hs),
      .cnt_i      (cfg_q.n_k),
      .last_o     (k_last),
      .pre_last_o (k_pre),
      .wrap_o     (k_wrap)
   );

   mmul_parallel_loop_cnt #(.CNT_W(TS_CNT_W)) u_cnt_n (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .clear_i    (idx_clr),
      .incr_i     (k_wrap),
      .cnt_i      (cfg_q.n_n),
      .last_o     (n_last),
      .pre_last_o (n_pre),
      .wrap_o     (n_wrap)
   );

   mmul_parallel_loop_cnt #(.CNT_W(TS_CNT_W)) u_cnt_m (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .clear_i    (idx_clr),
      .incr_i     (n_wrap),
      .cnt_i      (cfg_q.n_m),
      .last_o     (m_last),
      .pre_last_o (m_pre),
      .wrap_o     (m_wrap)
   );

   assign unused_cnt = ^{n_pre, m_pre, m_wrap};

   // Scheduler FSM: latch config, walk tiles with incremental offsets, emit the done pulse
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cfg_q   <= '0;
         desc_q  <= '0;
         a_row_q <= '0;
         b_col_q <= '0;
         c_row_q <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else if (clear_i) begin
         state_q <= IDLE;
         cfg_q   <= '0;
         desc_q  <= '0;
         a_row_q <= '0;
         b_col_q <= '0;
         c_row_q <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  cfg_q   <= cfg_in;
                  desc_q  <= '0;
                  a_row_q <= '0;
                  b_col_q <= '0;
                  c_row_q <= '0;
                  busy_q  <= 1'b1;
                  if (cfg_has_zero(cfg_in)) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q          <= ISSUE;
                     valid_q          <= 1'b1;
                     desc_q.acc_first <= 1'b1;
                     desc_q.acc_last  <= (cfg_in.n_k == TS_CNT_W'(1));
                  end
               end
            end
            ISSUE: begin
               if (hs) begin
                  if (tile_last) begin
                     state_q          <= DONE;
                     valid_q          <= 1'b0;
                     done_q           <= 1'b1;
                     desc_q.acc_first <= 1'b0;
                     desc_q.acc_last  <= 1'b0;
                  end else if (!k_last) begin
                     desc_q.a_offs    <= desc_q.a_offs + cfg_q.str_a_k;
                     desc_q.b_offs    <= desc_q.b_offs + cfg_q.str_b_k;
                     desc_q.acc_first <= 1'b0;
                     desc_q.acc_last  <= k_pre;
                  end else begin
                     desc_q.acc_first <= 1'b1;
                     desc_q.acc_last  <= (cfg_q.n_k == TS_CNT_W'(1));
                     if (!n_last) begin
                        b_col_q       <= b_col_q + cfg_q.str_b_n;
                        desc_q.a_offs <= a_row_q;
                        desc_q.b_offs <= b_col_q + cfg_q.str_b_n;
                        desc_q.c_offs <= desc_q.c_offs + cfg_q.str_c_n;
                     end else begin
                        a_row_q       <= a_row_q + cfg_q.str_a_m;
                        b_col_q       <= '0;
                        c_row_q       <= c_row_q + cfg_q.str_c_m;
                        desc_q.a_offs <= a_row_q + cfg_q.str_a_m;
                        desc_q.b_offs <= '0;
                        desc_q.c_offs <= c_row_q + cfg_q.str_c_m;
                     end
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

`ifdef MMUL_PARALLEL_TILE_SCHED_PERF_EN
   logic [31:0] perf_stall_q;

   // Stall counter: cycles a tile waits on the engine, saturating, restarted per job
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         perf_stall_q <= '0;
      end else if (clear_i || start_ok) begin
         perf_stall_q <= '0;
      end else if (valid_q && !tile_if.tile_ready && (perf_stall_q != '1)) begin
         perf_stall_q <= perf_stall_q + 32'd1;
      end
   end

   assign perf_stall_o = perf_stall_q;
`endif

   assign tile_if.tile_valid = valid_q;
   assign tile_if.a_offs     = OFFS_W'(desc_q.a_offs);
   assign tile_if.b_offs     = OFFS_W'(desc_q.b_offs);
   assign tile_if.c_offs     = OFFS_W'(desc_q.c_offs);
   assign tile_if.acc_first  = desc_q.acc_first;
   assign tile_if.acc_last   = desc_q.acc_last;
   assign busy_o             = busy_q;
   assign done_o             = done_q;

endmodule
